// File: rtl/regfile_wb_arbiter.sv
// +----------------------------------------------------------------------------+
// | regfile_wb_arbiter                                                         |
// | Round-robin arbiter sharing the register-file write port between sources.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
`default_nettype none

module regfile_wb_arbiter #(
  parameter int DATA_BITS = 32,
  parameter int NUM_REQ   = 4
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ*5-1:0]           req_rd_i,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data_i,
  input  logic                           hold_i,
  output logic                           wr_en_o,
  output logic [4:0]                     wr_sel_o,
  output logic [DATA_BITS-1:0]           wr_data_o,
  output logic [2:0]                     last_grant_o
);

  logic [2:0]           rr_ptr_q, rr_ptr_d;
  logic                 wr_en_q, wr_en_d;
  logic [4:0]           wr_sel_q, wr_sel_d;
  logic [DATA_BITS-1:0] wr_data_q, wr_data_d;
  logic [2:0]           last_grant_q, last_grant_d;

  logic [2:0]           w_ptr_eff;
  logic [2:0]           w_grant_idx;
  logic                 w_found;
  logic                 w_xfer;
  logic [4:0]           w_sel_rd;
  logic [DATA_BITS-1:0] w_sel_data;

  // Out-of-range pointer encodings fall back to requester 0.
  assign w_ptr_eff = ({1'b0, rr_ptr_q} >= 4'(NUM_REQ)) ? 3'd0 : rr_ptr_q;

  always_comb begin
    logic [3:0] sum;
    logic [2:0] idx;
    w_found     = 1'b0;
    w_grant_idx = 3'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, w_ptr_eff} + 4'(k);
      if (sum >= 4'(NUM_REQ)) begin
        sum = sum - 4'(NUM_REQ);
      end
      idx = sum[2:0];
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!w_found && idx == 3'(j) && req_valid_i[j]) begin
          w_found     = 1'b1;
          w_grant_idx = idx;
        end
      end
    end
  end

  assign w_xfer = w_found && !hold_i && !reset_i;

  always_comb begin
    req_ready_o = '0;
    w_sel_rd    = 5'd0;
    w_sel_data  = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_grant_idx == 3'(j)) begin
        req_ready_o[j] = w_xfer;
        w_sel_rd       = req_rd_i[5*j +: 5];
        w_sel_data     = req_data_i[DATA_BITS*j +: DATA_BITS];
      end
    end
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    wr_en_d      = 1'b0;
    wr_sel_d     = wr_sel_q;
    wr_data_d    = wr_data_q;
    last_grant_d = last_grant_q;
    if (w_xfer) begin
      rr_ptr_d     = ({1'b0, w_grant_idx} == 4'(NUM_REQ - 1)) ? 3'd0 : w_grant_idx + 3'd1;
      last_grant_d = w_grant_idx;
      wr_sel_d     = w_sel_rd;
      wr_data_d    = w_sel_data;
      // x0 writes complete the handshake but never reach the register file.
      wr_en_d      = (w_sel_rd != 5'd0);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rr_ptr_q     <= 3'd0;
      wr_en_q      <= 1'b0;
      wr_sel_q     <= 5'd0;
      wr_data_q    <= '0;
      last_grant_q <= 3'd0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      wr_en_q      <= wr_en_d;
      wr_sel_q     <= wr_sel_d;
      wr_data_q    <= wr_data_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign wr_en_o      = wr_en_q;
  assign wr_sel_o     = wr_sel_q;
  assign wr_data_o    = wr_data_q;
  assign last_grant_o = last_grant_q;

endmodule

`default_nettype wire
